// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: NRP read ports, one write port, and the soft-clear handshake.
// master drives addresses/writes/clear requests; slave is the register file.
interface reg_file_mp_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NRP   = 2
);
    logic [NRP*AW-1:0]    rd_addr;
    logic [NRP*WIDTH-1:0] rd_data;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 wr_ready;
    logic                 clr_req;
    logic                 busy;
    logic                 clr_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, wr_ready, busy, clr_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, wr_ready, busy, clr_done
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: 0-cycle reads, 1-cycle writes, DEPTH-cycle soft clear (wr_ready=0 while busy).
// Optional write-to-read forwarding with REGFILE_BYPASS_EN defined; default build has none.
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    reg_file_mp_if.slave  rf_if
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    state_t           state_q, state_d;
    logic [AW:0]      clr_ptr_q, clr_ptr_d;
    logic             clr_done_q, clr_done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic busy;
    logic wr_ok;

    // An address is usable when it is inside the array and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign busy           = (state_q == CLEAR);
    assign wr_ok          = rf_if.wr_en && !busy && addr_ok(rf_if.wr_addr);
    assign rf_if.busy     = busy;
    assign rf_if.wr_ready = !busy;
    assign rf_if.clr_done = clr_done_q;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rf_if.clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + PTR_ONE;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            clr_ptr_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            clr_done_q <= clr_done_d;
        end
    end

    // wr_ok excludes busy, so the sweep and a core write never target the array together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (busy) begin
            mem_q[clr_ptr_q[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem_q[rf_if.wr_addr] <= rf_if.wr_data;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd_word;

        assign ra = rf_if.rd_addr[k*AW +: AW];

        always_comb begin
            rd_word = '0;
            if (!busy && addr_ok(ra)) begin
                rd_word = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (rf_if.wr_addr == ra)) begin
                    rd_word = rf_if.wr_data;
                end
`endif
            end
        end

        assign rf_if.rd_data[k*WIDTH +: WIDTH] = rd_word;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (32 deep / zero reg, 24 deep / no zero reg) driven in lockstep.
module tb_reg_file_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra0, ra1, wr_addr;
    logic        wr_en, clr_req;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    reg_file_mp_if #(.WIDTH(32), .AW(5), .NRP(2)) if0 ();
    reg_file_mp_if #(.WIDTH(32), .AW(5), .NRP(2)) if1 ();

    assign if0.rd_addr = {ra1, ra0};
    assign if0.wr_en   = wr_en;
    assign if0.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;
    assign if0.clr_req = clr_req;
    assign if1.rd_addr = {ra1, ra0};
    assign if1.wr_en   = wr_en;
    assign if1.wr_addr = wr_addr;
    assign if1.wr_data = wr_data;
    assign if1.clr_req = clr_req;

    reg_file_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .NRP(2), .ZERO_REG(1)) u0 (
        .clk_i(clk), .reset_i(reset), .rf_if(if0));
    reg_file_mp #(.WIDTH(32), .DEPTH(24), .AW(5), .NRP(2), .ZERO_REG(0)) u1 (
        .clk_i(clk), .reset_i(reset), .rf_if(if1));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents, remaining busy cycles, expected clr_done.
    // A clear makes every entry unobservable until it ends, so the model zeroes all at the start.
    int          m_depth [2] = '{32, 24};
    bit          m_zr    [2] = '{1'b1, 1'b0};
    logic [31:0] m_mem   [2][32];
    int          m_left  [2];
    bit          m_done  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit valid_addr(input int d, input logic [4:0] a);
        return (int'(a) < m_depth[d]) && !(m_zr[d] && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
        if (m_left[d] > 0 || !valid_addr(d, a)) return 32'h0;
        if (BYP && wr_en && wr_addr == a) return wr_data;
        return m_mem[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
            m_left[d] = 0;
            m_done[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit nd;
            nd = (m_left[d] == 1);
            if (m_left[d] > 0) begin
                m_left[d]--;
            end else begin
                if (wr_en && valid_addr(d, wr_addr)) m_mem[d][wr_addr] = wr_data;
                if (clr_req) begin
                    for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
                    m_left[d] = m_depth[d];
                end
            end
            m_done[d] = nd;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [63:0] rdd;
            logic        bz, rdy, dn;
            if (d == 0) begin
                rdd = if0.rd_data; bz = if0.busy; rdy = if0.wr_ready; dn = if0.clr_done;
            end else begin
                rdd = if1.rd_data; bz = if1.busy; rdy = if1.wr_ready; dn = if1.clr_done;
            end
            chk($sformatf("d%0d rd0[%0d]", d, ra0), rdd[31:0],  exp_rd(d, ra0));
            chk($sformatf("d%0d rd1[%0d]", d, ra1), rdd[63:32], exp_rd(d, ra1));
            chk($sformatf("d%0d busy", d),     {31'b0, bz},  {31'b0, m_left[d] > 0});
            chk($sformatf("d%0d wr_ready", d), {31'b0, rdy}, {31'b0, m_left[d] == 0});
            chk($sformatf("d%0d clr_done", d), {31'b0, dn},  {31'b0, m_done[d]});
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared mid-cycle.
    task automatic tick();
        #4;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; ra0 = '0; ra1 = '0;
    endtask

    task automatic fill_all();
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = $urandom; ra0 = 5'(i); ra1 = 5'(i - 1);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((if0.busy || if1.busy) && k < 64) begin
            tick();
            k++;
        end
        chk(name, {31'b0, k < 64}, 32'd1);
    endtask

    task automatic count_clear(output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int c = 0; c < 40; c++) begin
            if (if0.busy) bc++;
            if (if0.clr_done) dc++;
            if (c == 5) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333_3333; ra0 = 5'd3;
                #1 chk("wr_ready during clear", {31'b0, if0.wr_ready}, 32'd0);
            end else if (c == 6) begin
                wr_en = 1'b0;
            end else if (c == 8) begin
                clr_req = 1'b1;
            end else if (c == 9) begin
                clr_req = 1'b0;
            end
            tick();
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc, dc;

        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h0000_1234, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 5'd7,  32'h1111_1111, 5'd1,  5'd2,  32'h0,         32'h0};
        vecs[5] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd5,  BYP ? 32'hA5A5_A5A5 : 32'h1111_1111, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[7] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30, BYP ? 32'hCAFE_F00D : 32'h0, 32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd7,  32'hCAFE_F00D, 32'hA5A5_A5A5};

        idle_inputs();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Directed vectors on the 32-deep instance
        for (int v = 0; v < 9; v++) begin
            wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
            ra0 = vecs[v].a0; ra1 = vecs[v].a1;
            #2;
            chk($sformatf("vec%0d port0", v), if0.rd_data[31:0],  vecs[v].e0);
            chk($sformatf("vec%0d port1", v), if0.rd_data[63:32], vecs[v].e1);
            tick();
        end
        wr_en = 1'b0;

        // 24-deep instance: r0 is ordinary, address 30 is out of range
        ra0 = 5'd0; #2;
        chk("d1 r0 ordinary", if1.rd_data[31:0], 32'h0000_1234);
        tick();
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h5A5A_5A5A; ra0 = 5'd30; #2;
        chk("d1 addr30 same cycle", if1.rd_data[31:0], 32'h0);
        tick();
        wr_en = 1'b0; #2;
        chk("d1 addr30 after write", if1.rd_data[31:0], 32'h0);
        tick();

        // Full clear with a dropped write and an ignored second request
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_clear(bc, dc);
        chk("clear busy cycles", 32'(bc), 32'd32);
        chk("clear done pulses", 32'(dc), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(31 - i); #2;
            if (i == 3 || i == 31) chk($sformatf("r%0d after clear", i), if0.rd_data[31:0], 32'h0);
            tick();
        end

        // Write and clear request in the same idle cycle
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_9999; clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0; ra0 = 5'd9;
        wait_idle("idle after write+clear");
        #2 chk("r9 cleared after write+clear", if0.rd_data[31:0], 32'h0);
        tick();

        // Reset during the sweep, then a fresh full sweep
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        reset = 1'b1;
        model_reset();
        #2 chk("busy drops on reset", {31'b0, if0.busy}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i += 4) begin
            ra0 = 5'(i + 1); ra1 = 5'(i + 2);
            tick();
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_clear(bc, dc);
        chk("restart busy cycles", 32'(bc), 32'd32);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            ra0     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            ra1     = 5'($urandom);
            clr_req = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
